tlb_array: RTL and testbench

//  16-entry fully associative MIPS32 joint TLB, the storage end of the CP0 TLB interface.

---
 rtl/tlb_array.sv | 234 +++++++++++++++++++++++
 tb/tb_tlb_array.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tlb_array.sv
// 16-entry fully associative MIPS32 joint TLB: TLBWI write, TLBR read, TLBP probe, two lookup ports.
// Optional macro TLB_FLUSH_EN adds a flush input that clears every entry's valid bits.
module tlb_array #(
  parameter int unsigned TLBNUM = 16
) (
  input  logic        clk,
  input  logic        resetn,
`ifdef TLB_FLUSH_EN
  input  logic        flush,
`endif
  input  logic        we,
  input  logic [3:0]  w_index,
  input  logic [18:0] w_vpn2,
  input  logic [7:0]  w_asid,
  input  logic        w_g,
  input  logic [19:0] w_pfn0,
  input  logic [2:0]  w_c0,
  input  logic        w_d0,
  input  logic        w_v0,
  input  logic [19:0] w_pfn1,
  input  logic [2:0]  w_c1,
  input  logic        w_d1,
  input  logic        w_v1,
  input  logic        r_req,
  input  logic [3:0]  r_index,
  output logic        r_valid,
  output logic [18:0] r_vpn2,
  output logic [7:0]  r_asid,
  output logic        r_g,
  output logic [19:0] r_pfn0,
  output logic [2:0]  r_c0,
  output logic        r_d0,
  output logic        r_v0,
  output logic [19:0] r_pfn1,
  output logic [2:0]  r_c1,
  output logic        r_d1,
  output logic        r_v1,
  input  logic        p_req,
  input  logic [18:0] p_vpn2,
  input  logic [7:0]  p_asid,
  output logic        p_valid,
  output logic        p_found,
  output logic [3:0]  p_index,
  input  logic        s0_req,
  input  logic [18:0] s0_vpn2,
  input  logic        s0_odd,
  input  logic [7:0]  s0_asid,
  output logic        s0_valid,
  output logic        s0_found,
  output logic [19:0] s0_pfn,
  output logic [2:0]  s0_c,
  output logic        s0_d,
  output logic        s0_v,
  output logic        s0_refill,
  output logic        s0_invalid,
  input  logic        s1_req,
  input  logic [18:0] s1_vpn2,
  input  logic        s1_odd,
  input  logic [7:0]  s1_asid,
  input  logic        s1_store,
  output logic        s1_valid,
  output logic        s1_found,
  output logic [19:0] s1_pfn,
  output logic [2:0]  s1_c,
  output logic        s1_d,
  output logic        s1_v,
  output logic        s1_refill,
  output logic        s1_invalid,
  output logic        s1_modified
);

  localparam int unsigned IDXW  = $clog2(TLBNUM);
  localparam int unsigned VPNW  = 19;
  localparam int unsigned ASIDW = 8;
  localparam int unsigned PFNW  = 20;
  localparam int unsigned CW    = 3;

  typedef struct packed {
    logic [VPNW-1:0]  vpn2;
    logic [ASIDW-1:0] asid;
    logic             g;
    logic [PFNW-1:0]  pfn0;
    logic [CW-1:0]    c0;
    logic             d0;
    logic             v0;
    logic [PFNW-1:0]  pfn1;
    logic [CW-1:0]    c1;
    logic             d1;
    logic             v1;
  } entry_t;

  typedef struct packed {
    logic            found;
    logic [IDXW-1:0] idx;
  } hit_t;

  typedef struct packed {
    logic            found;
    logic [PFNW-1:0] pfn;
    logic [CW-1:0]   c;
    logic            d;
    logic            v;
    logic            refill;
    logic            invalid;
  } lk_t;

  entry_t tlb_q [TLBNUM];

  entry_t r_q;
  hit_t   p_q;
  lk_t    s0_q, s1_q;
  logic   r_valid_q, p_valid_q, s0_valid_q, s1_valid_q, s1_mod_q;

  hit_t   p_hit_c;
  lk_t    s0_lk_c, s1_lk_c;
  logic   s1_mod_c;

  // Associative match; scanning downward lets the lowest matching index win.
  function automatic hit_t match_f(input logic [VPNW-1:0] vpn2, input logic [ASIDW-1:0] asid);
    hit_t h;
    h = '0;
    for (int i = int'(TLBNUM) - 1; i >= 0; i--) begin
      if (tlb_q[i].vpn2 == vpn2 && (tlb_q[i].g || tlb_q[i].asid == asid)) begin
        h.found = 1'b1;
        h.idx   = IDXW'(i);
      end
    end
    return h;
  endfunction

  function automatic lk_t lookup_f(input logic [VPNW-1:0] vpn2, input logic odd,
                                   input logic [ASIDW-1:0] asid);
    hit_t   h;
    entry_t e;
    lk_t    r;
    h = match_f(vpn2, asid);
    e = tlb_q[h.idx];
    r = '0;
    if (h.found) begin
      r.found = 1'b1;
      if (odd) {r.pfn, r.c, r.d, r.v} = {e.pfn1, e.c1, e.d1, e.v1};
      else     {r.pfn, r.c, r.d, r.v} = {e.pfn0, e.c0, e.d0, e.v0};
      r.invalid = ~r.v;
    end else begin
      r.refill = 1'b1;
    end
    return r;
  endfunction

  always_comb begin
    p_hit_c  = match_f(p_vpn2, p_asid);
    s0_lk_c  = lookup_f(s0_vpn2, s0_odd, s0_asid);
    s1_lk_c  = lookup_f(s1_vpn2, s1_odd, s1_asid);
    s1_mod_c = s1_lk_c.found & s1_lk_c.v & ~s1_lk_c.d & s1_store;
  end

  // Entry storage; reset only invalidates, a flush overrides a same-edge write's valid bits.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < int'(TLBNUM); i++) begin
        tlb_q[i].v0 <= 1'b0;
        tlb_q[i].v1 <= 1'b0;
        tlb_q[i].g  <= 1'b0;
      end
    end else begin
      if (we) begin
        tlb_q[w_index] <= {w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0,
                           w_pfn1, w_c1, w_d1, w_v1};
      end
`ifdef TLB_FLUSH_EN
      if (flush) begin
        for (int i = 0; i < int'(TLBNUM); i++) begin
          tlb_q[i].v0 <= 1'b0;
          tlb_q[i].v1 <= 1'b0;
        end
      end
`endif
    end
  end

  // Response registers: strobes pulse for one cycle, data holds until the next request.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_valid_q  <= 1'b0;
      p_valid_q  <= 1'b0;
      s0_valid_q <= 1'b0;
      s1_valid_q <= 1'b0;
      r_q        <= '0;
      p_q        <= '0;
      s0_q       <= '0;
      s1_q       <= '0;
      s1_mod_q   <= 1'b0;
    end else begin
      r_valid_q  <= r_req;
      p_valid_q  <= p_req;
      s0_valid_q <= s0_req;
      s1_valid_q <= s1_req;
      if (r_req)  r_q  <= tlb_q[r_index];
      if (p_req)  p_q  <= p_hit_c;
      if (s0_req) s0_q <= s0_lk_c;
      if (s1_req) begin
        s1_q     <= s1_lk_c;
        s1_mod_q <= s1_mod_c;
      end
    end
  end

  assign r_valid = r_valid_q;
  assign {r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1} = r_q;

  assign p_valid = p_valid_q;
  assign p_found = p_q.found;
  assign p_index = p_q.idx;

  assign s0_valid   = s0_valid_q;
  assign s0_found   = s0_q.found;
  assign s0_pfn     = s0_q.pfn;
  assign s0_c       = s0_q.c;
  assign s0_d       = s0_q.d;
  assign s0_v       = s0_q.v;
  assign s0_refill  = s0_q.refill;
  assign s0_invalid = s0_q.invalid;

  assign s1_valid    = s1_valid_q;
  assign s1_found    = s1_q.found;
  assign s1_pfn      = s1_q.pfn;
  assign s1_c        = s1_q.c;
  assign s1_d        = s1_q.d;
  assign s1_v        = s1_q.v;
  assign s1_refill   = s1_q.refill;
  assign s1_invalid  = s1_q.invalid;
  assign s1_modified = s1_mod_q;

endmodule

// File: tb/tb_tlb_array.sv
// Directed self-checking bench for tlb_array; define TLB_FLUSH_EN to also exercise flush.
module tb_tlb_array;

  logic        clk, resetn;
`ifdef TLB_FLUSH_EN
  logic        flush;
`endif
  logic        we;
  logic [3:0]  w_index;
  logic [18:0] w_vpn2;
  logic [7:0]  w_asid;
  logic        w_g;
  logic [19:0] w_pfn0, w_pfn1;
  logic [2:0]  w_c0, w_c1;
  logic        w_d0, w_v0, w_d1, w_v1;
  logic        r_req;
  logic [3:0]  r_index;
  logic        r_valid;
  logic [18:0] r_vpn2;
  logic [7:0]  r_asid;
  logic        r_g;
  logic [19:0] r_pfn0, r_pfn1;
  logic [2:0]  r_c0, r_c1;
  logic        r_d0, r_v0, r_d1, r_v1;
  logic        p_req;
  logic [18:0] p_vpn2;
  logic [7:0]  p_asid;
  logic        p_valid, p_found;
  logic [3:0]  p_index;
  logic        s0_req, s0_odd;
  logic [18:0] s0_vpn2;
  logic [7:0]  s0_asid;
  logic        s0_valid, s0_found, s0_d, s0_v, s0_refill, s0_invalid;
  logic [19:0] s0_pfn;
  logic [2:0]  s0_c;
  logic        s1_req, s1_odd, s1_store;
  logic [18:0] s1_vpn2;
  logic [7:0]  s1_asid;
  logic        s1_valid, s1_found, s1_d, s1_v, s1_refill, s1_invalid, s1_modified;
  logic [19:0] s1_pfn;
  logic [2:0]  s1_c;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  tlb_array dut (
    .clk(clk), .resetn(resetn),
`ifdef TLB_FLUSH_EN
    .flush(flush),
`endif
    .we(we), .w_index(w_index), .w_vpn2(w_vpn2), .w_asid(w_asid), .w_g(w_g),
    .w_pfn0(w_pfn0), .w_c0(w_c0), .w_d0(w_d0), .w_v0(w_v0),
    .w_pfn1(w_pfn1), .w_c1(w_c1), .w_d1(w_d1), .w_v1(w_v1),
    .r_req(r_req), .r_index(r_index), .r_valid(r_valid),
    .r_vpn2(r_vpn2), .r_asid(r_asid), .r_g(r_g),
    .r_pfn0(r_pfn0), .r_c0(r_c0), .r_d0(r_d0), .r_v0(r_v0),
    .r_pfn1(r_pfn1), .r_c1(r_c1), .r_d1(r_d1), .r_v1(r_v1),
    .p_req(p_req), .p_vpn2(p_vpn2), .p_asid(p_asid),
    .p_valid(p_valid), .p_found(p_found), .p_index(p_index),
    .s0_req(s0_req), .s0_vpn2(s0_vpn2), .s0_odd(s0_odd), .s0_asid(s0_asid),
    .s0_valid(s0_valid), .s0_found(s0_found), .s0_pfn(s0_pfn), .s0_c(s0_c),
    .s0_d(s0_d), .s0_v(s0_v), .s0_refill(s0_refill), .s0_invalid(s0_invalid),
    .s1_req(s1_req), .s1_vpn2(s1_vpn2), .s1_odd(s1_odd), .s1_asid(s1_asid),
    .s1_store(s1_store),
    .s1_valid(s1_valid), .s1_found(s1_found), .s1_pfn(s1_pfn), .s1_c(s1_c),
    .s1_d(s1_d), .s1_v(s1_v), .s1_refill(s1_refill), .s1_invalid(s1_invalid),
    .s1_modified(s1_modified)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the active edge, outputs are read at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    we = 1'b0; r_req = 1'b0; p_req = 1'b0; s0_req = 1'b0; s1_req = 1'b0;
`ifdef TLB_FLUSH_EN
    flush = 1'b0;
`endif
  endtask

  task automatic set_wr(input logic [3:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                        input logic g, input logic [19:0] pfn0, input logic [2:0] c0,
                        input logic d0, input logic v0, input logic [19:0] pfn1,
                        input logic [2:0] c1, input logic d1, input logic v1);
    we = 1'b1; w_index = idx; w_vpn2 = vpn2; w_asid = asid; w_g = g;
    w_pfn0 = pfn0; w_c0 = c0; w_d0 = d0; w_v0 = v0;
    w_pfn1 = pfn1; w_c1 = c1; w_d1 = d1; w_v1 = v1;
  endtask

  task automatic set_s0(input logic [18:0] vpn2, input logic odd, input logic [7:0] asid);
    s0_req = 1'b1; s0_vpn2 = vpn2; s0_odd = odd; s0_asid = asid;
  endtask

  task automatic set_s1(input logic [18:0] vpn2, input logic odd, input logic [7:0] asid,
                        input logic store);
    s1_req = 1'b1; s1_vpn2 = vpn2; s1_odd = odd; s1_asid = asid; s1_store = store;
  endtask

  initial begin
    resetn = 1'b0;
    clear_reqs();
    set_wr(4'd0, 19'h0, 8'h0, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0);
    we = 1'b0;
    r_index = 4'd0; p_vpn2 = 19'h0; p_asid = 8'h0;
    s0_vpn2 = 19'h0; s0_odd = 1'b0; s0_asid = 8'h0;
    s1_vpn2 = 19'h0; s1_odd = 1'b0; s1_asid = 8'h0; s1_store = 1'b0;
    tick();
    tick();
    chk("rst_r_valid", 32'(r_valid), 0);
    chk("rst_p_valid", 32'(p_valid), 0);
    chk("rst_p_index", 32'(p_index), 0);
    chk("rst_s0_valid", 32'(s0_valid), 0);
    chk("rst_s1_refill", 32'(s1_refill), 0);
    resetn = 1'b1;

    // Fill every entry with a harmless non-matching, invalid mapping.
    for (int i = 0; i < 16; i++) begin
      set_wr(4'(i), 19'h40000 | 19'(i), 8'hFF, 1'b0, 20'(i), 3'd0, 1'b0, 1'b0,
             20'(i), 3'd0, 1'b0, 1'b0);
      tick();
    end
    clear_reqs();

    // 1: basic hit, then ASID mismatch miss.
    set_wr(4'd3, 19'h1, 8'h05, 1'b0, 20'hABCDE, 3'd3, 1'b1, 1'b1, 20'h12345, 3'd2, 1'b0, 1'b0);
    tick(); clear_reqs();
    set_s0(19'h1, 1'b0, 8'h05);
    tick(); clear_reqs();
    chk("t1_s0_valid", 32'(s0_valid), 1);
    chk("t1_s0_found", 32'(s0_found), 1);
    chk("t1_s0_pfn", 32'(s0_pfn), 32'hABCDE);
    chk("t1_s0_c", 32'(s0_c), 3);
    chk("t1_s0_refill", 32'(s0_refill), 0);
    chk("t1_s0_invalid", 32'(s0_invalid), 0);
    set_s0(19'h1, 1'b0, 8'h06);
    tick(); clear_reqs();
    chk("t1_miss_valid", 32'(s0_valid), 1);
    chk("t1_miss_refill", 32'(s0_refill), 1);
    chk("t1_miss_found", 32'(s0_found), 0);
    chk("t1_miss_pfn", 32'(s0_pfn), 0);
    tick();
    chk("t1_valid_pulse", 32'(s0_valid), 0);
    chk("t1_data_hold", 32'(s0_refill), 1);

    // 2: probe with two matching entries (idx2 global), then a probe miss.
    set_wr(4'd2, 19'h55, 8'h01, 1'b1, 20'h2, 3'd0, 1'b0, 1'b1, 20'h2, 3'd0, 1'b0, 1'b1);
    tick();
    set_wr(4'd7, 19'h55, 8'h09, 1'b0, 20'h7, 3'd0, 1'b0, 1'b1, 20'h7, 3'd0, 1'b0, 1'b1);
    tick(); clear_reqs();
    p_req = 1'b1; p_vpn2 = 19'h55; p_asid = 8'h09;
    tick(); clear_reqs();
    chk("t2_p_valid", 32'(p_valid), 1);
    chk("t2_p_found", 32'(p_found), 1);
    chk("t2_p_index", 32'(p_index), 2);
    p_req = 1'b1; p_vpn2 = 19'h66; p_asid = 8'h09;
    tick(); clear_reqs();
    chk("t2_miss_valid", 32'(p_valid), 1);
    chk("t2_miss_found", 32'(p_found), 0);

    // 3: read in the same cycle as a write sees old contents, next cycle sees new.
    set_wr(4'd4, 19'h77, 8'h10, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0, 20'hFEDCB, 3'd5, 1'b0, 1'b1);
    r_req = 1'b1; r_index = 4'd4;
    tick(); clear_reqs();
    chk("t3_old_valid", 32'(r_valid), 1);
    chk("t3_old_vpn2", 32'(r_vpn2), 32'h40004);
    chk("t3_old_v1", 32'(r_v1), 0);
    r_req = 1'b1; r_index = 4'd4;
    tick(); clear_reqs();
    chk("t3_new_vpn2", 32'(r_vpn2), 32'h77);
    chk("t3_new_v1", 32'(r_v1), 1);
    chk("t3_new_pfn1", 32'(r_pfn1), 32'hFEDCB);
    chk("t3_new_asid", 32'(r_asid), 32'h10);

    // 4: store to clean odd page, same access as load, invalid odd page; both ports at once.
    set_s1(19'h77, 1'b1, 8'h10, 1'b1);
    set_s0(19'h1, 1'b1, 8'h05);
    tick(); clear_reqs();
    chk("t4_st_valid", 32'(s1_valid), 1);
    chk("t4_st_modified", 32'(s1_modified), 1);
    chk("t4_st_pfn", 32'(s1_pfn), 32'hFEDCB);
    chk("t4_s0_odd_pfn", 32'(s0_pfn), 32'h12345);
    chk("t4_s0_odd_invalid", 32'(s0_invalid), 1);
    set_s1(19'h77, 1'b1, 8'h10, 1'b0);
    tick(); clear_reqs();
    chk("t4_ld_modified", 32'(s1_modified), 0);
    chk("t4_ld_found", 32'(s1_found), 1);
    set_s1(19'h1, 1'b1, 8'h05, 1'b1);
    tick(); clear_reqs();
    chk("t4_inv_found", 32'(s1_found), 1);
    chk("t4_inv_invalid", 32'(s1_invalid), 1);
    chk("t4_inv_modified", 32'(s1_modified), 0);
    chk("t4_inv_refill", 32'(s1_refill), 0);

    // 5: requests during reset are dropped; contents survive with valid bits cleared.
    resetn = 1'b0;
    p_req = 1'b1; p_vpn2 = 19'h55; p_asid = 8'h09;
    set_s0(19'h1, 1'b0, 8'h05);
    tick(); clear_reqs();
    chk("t5_p_valid", 32'(p_valid), 0);
    chk("t5_s0_valid", 32'(s0_valid), 0);
    chk("t5_p_found", 32'(p_found), 0);
    chk("t5_s1_modified", 32'(s1_modified), 0);
    resetn = 1'b1;
    tick();
    chk("t5_post_p_valid", 32'(p_valid), 0);
    chk("t5_post_s0_valid", 32'(s0_valid), 0);
    set_s0(19'h1, 1'b0, 8'h05);
    tick(); clear_reqs();
    chk("t5_found", 32'(s0_found), 1);
    chk("t5_invalid", 32'(s0_invalid), 1);
    chk("t5_pfn", 32'(s0_pfn), 32'hABCDE);

`ifdef TLB_FLUSH_EN
    // 6: lookup in the flush cycle sees pre-flush contents, afterwards the page is invalid.
    set_wr(4'd3, 19'h1, 8'h05, 1'b0, 20'hABCDE, 3'd3, 1'b1, 1'b1, 20'h12345, 3'd2, 1'b0, 1'b0);
    tick(); clear_reqs();
    flush = 1'b1;
    set_s0(19'h1, 1'b0, 8'h05);
    tick(); clear_reqs();
    chk("t6_flush_hit", 32'(s0_found), 1);
    chk("t6_flush_v", 32'(s0_v), 1);
    set_s0(19'h1, 1'b0, 8'h05);
    tick(); clear_reqs();
    chk("t6_after_invalid", 32'(s0_invalid), 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
